// File: rtl/write_buffer.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : write_buffer                                               |
// | Description : Posted-write FIFO between the D-cache dirty-line write     |
// |               port and the memory arbiter's D-cache write port. Accepts  |
// |               evicted lines in a single cycle and drains them to memory  |
// |               in acceptance order. Answers line-address lookups so a     |
// |               refill never reads stale memory for a still-queued line.   |
// | Options     : WRITE_BUFFER_COALESCE_EN - when defined, a write whose line |
// |               matches a queued non-head entry overwrites that entry's    |
// |               data in place instead of allocating a new slot.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------

`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 128
`endif

module write_buffer #(
   parameter int WIDTH = `MEMORY_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   // cache write side
   input  logic                     wr_req,
   output logic                     wr_ack,
   input  logic [31:0]              wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   // arbiter drain side
   output logic                     mem_write_req,
   input  logic                     mem_write_ack,
   output logic [31:0]              mem_write_addr,
   output logic [WIDTH-1:0]         mem_write_data,
   // refill lookup side
   input  logic [31:0]              rd_addr,
   output logic                     rd_hit,
   output logic [WIDTH-1:0]         rd_data,
   // occupancy
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   // Pointer width and the number of byte-offset bits inside one line.
   localparam int          c_PW        = $clog2(DEPTH);
   localparam int          c_OFFS      = $clog2(WIDTH / 8);
   // Clears the byte-offset bits so only the line address takes part in matches.
   localparam logic [31:0] c_LINE_MASK = ~((32'd1 << c_OFFS) - 32'd1);
   localparam logic [c_PW:0] c_FULL    = (c_PW + 1)'(DEPTH);

   // Entry storage and queue bookkeeping.
   logic [31:0]      r_addr [DEPTH];
   logic [WIDTH-1:0] r_data [DEPTH];
   logic [c_PW-1:0]  r_head;
   logic [c_PW-1:0]  r_tail;
   logic [c_PW:0]    r_count;

   // Per-age view of the queue: age 0 is the head, age count-1 the youngest.
   logic [c_PW-1:0]  w_slot     [DEPTH];
   logic [DEPTH-1:0] w_live;
   logic [DEPTH-1:0] w_rd_match;

   logic [31:0]      w_wr_line;
   logic [31:0]      w_rd_line;
   logic             w_full;
   logic             w_empty;
   logic             w_rd_hit;
   logic [c_PW-1:0]  w_rd_slot;
   logic             w_co_hit;
   logic [c_PW-1:0]  w_co_slot;
   logic             w_wr_ack;
   logic             w_enq;
   logic             w_upd;
   logic             w_deq;

   assign w_wr_line = wr_addr & c_LINE_MASK;
   assign w_rd_line = rd_addr & c_LINE_MASK;

   // Occupancy flags come straight from the registered count.
   assign w_full  = (r_count == c_FULL);
   assign w_empty = (r_count == '0);

   // Map each age to its physical slot and flag which ages hold valid entries.
   for (genvar k = 0; k < DEPTH; k++) begin : g_slot
      assign w_slot[k]     = r_head + c_PW'(k);
      assign w_live[k]     = ((c_PW + 1)'(k) < r_count);
      assign w_rd_match[k] = w_live[k] && (r_addr[w_slot[k]] == w_rd_line);
   end

   // Lookup: scan from head toward tail so the youngest matching entry wins.
   always_comb begin
      w_rd_hit  = 1'b0;
      w_rd_slot = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (w_rd_match[k]) begin
            w_rd_hit  = 1'b1;
            w_rd_slot = w_slot[k];
         end
      end
   end

`ifdef WRITE_BUFFER_COALESCE_EN
   // Coalesce search: youngest valid non-head entry on the same line. The head
   // is excluded because the arbiter may already be consuming its data.
   always_comb begin
      w_co_hit  = 1'b0;
      w_co_slot = '0;
      for (int k = 1; k < DEPTH; k++) begin
         if (w_live[k] && (r_addr[w_slot[k]] == w_wr_line)) begin
            w_co_hit  = 1'b1;
            w_co_slot = w_slot[k];
         end
      end
   end
`else
   // Every accepted write allocates a fresh entry.
   assign w_co_hit  = 1'b0;
   assign w_co_slot = '0;
`endif

   // A coalescing write needs no free slot, so it is accepted even when full.
   assign w_wr_ack = wr_req & ~reset & (w_co_hit | ~w_full);
   assign w_enq    = w_wr_ack & ~w_co_hit;
   assign w_upd    = w_wr_ack &  w_co_hit;
   assign w_deq    = mem_write_ack & ~w_empty;

   // Queue state update: enqueue at tail, in-place merge, dequeue at head.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_addr[i] <= '0;
            r_data[i] <= '0;
         end
      end else begin
         if (w_enq) begin
            r_addr[r_tail] <= w_wr_line;
            r_data[r_tail] <= wr_data;
            r_tail         <= r_tail + 1'b1;
         end
         if (w_upd) begin
            r_data[w_co_slot] <= wr_data;
         end
         if (w_deq) begin
            r_head <= r_head + 1'b1;
         end
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign wr_ack         = w_wr_ack;
   assign mem_write_req  = ~w_empty;
   assign mem_write_addr = r_addr[r_head];
   assign mem_write_data = r_data[r_head];
   assign rd_hit         = w_rd_hit;
   assign rd_data        = w_rd_hit ? r_data[w_rd_slot] : '0;
   assign full           = w_full;
   assign empty          = w_empty;
   assign count          = r_count;

endmodule

`default_nettype wire

// File: doc/write_buffer.md
# write_buffer

Posted-write FIFO between the D-cache dirty-line write port and the memory arbiter's D-cache write port. It accepts evicted lines from the cache in one cycle while memory is busy, so cache refills are not held behind write-backs. It drains entries to the arbiter in FIFO order. It also answers line-address lookups so a refill never reads stale memory for a line still queued.

## Interface
Parameters:
- WIDTH, `MEMORY_WIDTH: line width in bits. Must be a multiple of 8, with WIDTH/8 a power of two.
- DEPTH, 4: number of entries. Must be a power of two, 2..16.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- wr_req  in  1  cache requests a line write; held until wr_ack
- wr_ack  out  1  write accepted this cycle (combinational)
- wr_addr  in  32  line address of the write
- wr_data  in  WIDTH  line data
- mem_write_req  out  1  head entry pending toward arbiter
- mem_write_ack  in  1  arbiter completed head write (1-cycle pulse)
- mem_write_addr  out  32  head entry address
- mem_write_data  out  WIDTH  head entry data
- rd_addr  in  32  lookup address from cache refill path
- rd_hit  out  1  a queued entry matches rd_addr (combinational)
- rd_data  out  WIDTH  data of youngest matching entry; 0 when no hit
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  $clog2(DEPTH)+1  valid entries

## Operation
- Storage: circular array of DEPTH entries {addr, data}. Head pointer, tail pointer, and count are registered. Pointers wrap modulo DEPTH.
- Line match: compare addr[31:$clog2(WIDTH/8)]. Offset bits are ignored. Stored addr has offset bits forced to 0.
- Enqueue: wr_ack = wr_req & ~full & ~reset. On the edge with wr_ack=1, write the entry at tail, tail+1, count+1.
- Dequeue: mem_write_req = ~empty. mem_write_addr/data = head entry, stable while mem_write_req=1. On the edge with mem_write_ack & ~empty: head+1, count-1.
- mem_write_ack while empty: ignored, no state change.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- When full, wr_ack=0 even if mem_write_ack is high the same cycle. There is no full-bypass. Acceptance resumes the next cycle.
- Lookup: rd_hit = OR over valid entries of line match. rd_data comes from the matching entry nearest tail (youngest). The entry being enqueued this cycle is not visible until the next cycle.
- Empty-to-head: an entry enqueued at cycle N appears on mem_write_req at cycle N+1.
- Entries are never reordered. Memory sees writes in acceptance order.

## Timing
- Reset values: count=0, empty=1, full=0, mem_write_req=0, wr_ack=0, rd_hit=0, rd_data=0. mem_write_addr/data=0 (array cleared).
- Reset mid-operation: all queued entries are discarded, and a pending mem_write_ack that same cycle is ignored. The cache must re-issue if required, because reset is global.
- Accept latency: 0 cycles (ack in request cycle). Visible to lookup and drain: 1 cycle.
- Drain throughput: one entry per mem_write_ack. The arbiter may ack no sooner than the cycle after mem_write_req rises for that entry.
- full, empty, and count are decoded from registered count. They are glitch-free relative to clk.

## Configuration
- WRITE_BUFFER_COALESCE_EN defined: a write whose line matches a valid non-head entry overwrites that entry's data in place. wr_ack=1 even when full, and count, tail, and head are unchanged. If several entries match, the youngest is overwritten. A match on the head only (head is presented to the arbiter) enqueues normally.
- Undefined: every accepted write allocates a new entry, and duplicate lines may coexist. rd_data still returns the youngest.

## Test plan
- Reset then idle: hold reset 2 cycles -> count=0, empty=1, mem_write_req=0. Pulse mem_write_ack with no entries -> no change.
- Fill and block, DEPTH=4: write A=0x100..0x130 with data 1..4, no acks -> count=4, full=1. A fifth wr_req gives wr_ack=0. mem_write_addr=0x100, data=1.
- Drain order: from full, ack every other cycle -> addresses 0x100, 0x110, 0x120, 0x130 in order, then empty=1 and mem_write_req=0. Pointers wrap correctly on a second fill.
- Simultaneous ops at count=2: wr_req and mem_write_ack in the same cycle -> count stays 2, head advances, new entry at tail.
- Lookup: queue 0x200 (data 0xAA) then 0x240 (data 0xBB), set rd_addr=0x204 -> rd_hit=1, rd_data=0xAA. rd_addr=0x300 -> rd_hit=0, rd_data=0.
- Coalesce (macro on): queue 0x100, 0x200, then write 0x200 with data 0xCC -> count stays 2 and drained data for 0x200 is 0xCC. With the macro off -> count=3 and lookup on 0x200 returns 0xCC.
